// File: rtl/melody_seq.sv
// Note sequencer: plays a 32-entry writable song memory (note, octave, beats)
// at a programmable tempo, presenting a period value and gate to the tone generator.
module melody_seq #(
    parameter logic [24:0] BEAT_MAX   = 25'd12_499_999,
    parameter logic [19:0] GAP_CYCLES = 20'd999_999,
    parameter logic [17:0] DO         = 18'd190_839,
    parameter logic [17:0] RE         = 18'd170_067,
    parameter logic [17:0] MI         = 18'd151_515,
    parameter logic [17:0] FA         = 18'd143_266,
    parameter logic [17:0] SO         = 18'd127_551,
    parameter logic [17:0] LA         = 18'd113_636,
    parameter logic [17:0] SI         = 18'd101_214
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic [4:0]  len_last,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [17:0] freq_data,
    output logic        tone_en,
    output logic        note_strobe,
    output logic [4:0]  note_idx,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

    state_t      state, state_n;
    logic [24:0] beat_cnt, beat_cnt_n;
    logic [2:0]  beats_left, beats_left_n;
    logic [19:0] gap_cnt, gap_cnt_n;
    logic [17:0] freq_n;
    logic        tone_n, strobe_n, busy_n;
    logic [4:0]  idx_n;

    logic [7:0]  mem [32];
    logic [7:0]  rd_data;
    logic [17:0] base, period;

    // The read address is the next entry index, so the entry is already in
    // rd_data during FETCH and a write landing in FETCH is only seen next pass.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[idx_n];
    end

    always_comb begin
        case (rd_data[7:5])
            3'd1:    base = DO;
            3'd2:    base = RE;
            3'd3:    base = MI;
            3'd4:    base = FA;
            3'd5:    base = SO;
            3'd6:    base = LA;
            3'd7:    base = SI;
            default: base = '0;
        endcase
        case (rd_data[4:3])
            2'd1:    period = base >> 1;
            2'd2:    period = base >> 2;
            default: period = base;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            beats_left  <= '0;
            gap_cnt     <= '0;
            freq_data   <= '0;
            tone_en     <= 1'b0;
            note_strobe <= 1'b0;
            note_idx    <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            beat_cnt    <= beat_cnt_n;
            beats_left  <= beats_left_n;
            gap_cnt     <= gap_cnt_n;
            freq_data   <= freq_n;
            tone_en     <= tone_n;
            note_strobe <= strobe_n;
            note_idx    <= idx_n;
            busy        <= busy_n;
        end
    end

    always_comb begin
        state_n      = state;
        beat_cnt_n   = beat_cnt;
        beats_left_n = beats_left;
        gap_cnt_n    = gap_cnt;
        freq_n       = freq_data;
        tone_n       = tone_en;
        strobe_n     = 1'b0;
        idx_n        = note_idx;
        busy_n       = busy;

        if (stop) begin
            state_n      = IDLE;
            beat_cnt_n   = '0;
            beats_left_n = '0;
            gap_cnt_n    = '0;
            freq_n       = '0;
            tone_n       = 1'b0;
            idx_n        = '0;
            busy_n       = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = FETCH;
                        idx_n   = '0;
                        busy_n  = 1'b1;
                    end
                end
                FETCH: begin
                    state_n      = PLAY;
                    freq_n       = period;
                    tone_n       = (rd_data[7:5] != 3'd0);
                    strobe_n     = 1'b1;
                    beat_cnt_n   = '0;
                    beats_left_n = rd_data[2:0];
                end
                PLAY: begin
                    if (beat_cnt == BEAT_MAX) begin
                        beat_cnt_n = '0;
                        if (beats_left == 3'd0) begin
                            state_n   = GAP;
                            tone_n    = 1'b0;
                            gap_cnt_n = '0;
                        end else begin
                            beats_left_n = beats_left - 3'd1;
                        end
                    end else begin
                        beat_cnt_n = beat_cnt + 25'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_CYCLES) begin
                        gap_cnt_n = '0;
                        if (note_idx != len_last) begin
                            state_n = FETCH;
                            idx_n   = note_idx + 5'd1;
                        end else if (loop) begin
                            state_n = FETCH;
                            idx_n   = '0;
                        end else begin
                            state_n = IDLE;
                            idx_n   = '0;
                            freq_n  = '0;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        gap_cnt_n = gap_cnt + 20'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: vector table of single-entry songs, hand-written corner
// sequences, and random songs checked against a cycle timeline built from the song.
module tb_melody_seq;

    localparam logic [24:0] BM   = 25'd9;
    localparam logic [19:0] GC   = 20'd2;
    localparam int          BEAT = 10;
    localparam int          GAPN = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst, start, stop, loop, wr_en;
    logic [4:0]  len_last, wr_addr;
    logic [7:0]  wr_data;
    logic [17:0] freq_data;
    logic        tone_en, note_strobe, busy;
    logic [4:0]  note_idx;

    melody_seq #(.BEAT_MAX(BM), .GAP_CYCLES(GC)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
        .loop(loop), .len_last(len_last), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .freq_data(freq_data), .tone_en(tone_en),
        .note_strobe(note_strobe), .note_idx(note_idx), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int freq;
        int tone;
        int strobe;
        int idx;
        int busy;
    } obs_t;

    typedef struct {
        logic [7:0] data;
        int         freq;
        int         tone;
        int         play;
    } vec_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] song [32];
    int         base_tab [8] = '{0, 190839, 170067, 151515, 143266, 127551, 113636, 101214};
    obs_t       expq [$];
    int         strobe_at [$];

    function automatic obs_t mk(int f, int t, int s, int i, int b);
        obs_t o;
        o.freq = f; o.tone = t; o.strobe = s; o.idx = i; o.busy = b;
        return o;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, act, req);
        end
    endtask

    task automatic checkObs(string name, obs_t e);
        n_cmp++;
        if (int'(freq_data) != e.freq || int'(tone_en) != e.tone || int'(note_strobe) != e.strobe ||
            int'(note_idx) != e.idx || int'(busy) != e.busy) begin
            n_fail++;
            $display("[TB] FAIL %s: got freq=%0d tone=%0d strobe=%0d idx=%0d busy=%0d, wanted freq=%0d tone=%0d strobe=%0d idx=%0d busy=%0d",
                     name, freq_data, tone_en, note_strobe, note_idx, busy,
                     e.freq, e.tone, e.strobe, e.idx, e.busy);
        end
    endtask

    task automatic writeEntry(int addr, logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_data = data;
        song[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Expected outputs for cycles t+1, t+2, ... after start at cycle t, expanded
    // entry by entry from the song contents and the tempo arithmetic.
    task automatic buildModel(int n_max, bit lp, int last);
        int idx, code, oct, beats, per;
        expq.delete();
        idx = 0;
        expq.push_back(mk(0, 0, 0, 0, 1));
        while (expq.size() < n_max) begin
            code  = int'(song[idx][7:5]);
            oct   = int'(song[idx][4:3]);
            beats = int'(song[idx][2:0]) + 1;
            per   = base_tab[code] / ((oct == 1) ? 2 : (oct == 2) ? 4 : 1);
            for (int k = 0; k < beats * BEAT; k++)
                expq.push_back(mk(per, (code != 0) ? 1 : 0, (k == 0) ? 1 : 0, idx, 1));
            for (int k = 0; k < GAPN; k++)
                expq.push_back(mk(per, 0, 0, idx, 1));
            if (idx != last) begin
                idx = (idx + 1) % 32;
            end else if (lp) begin
                idx = 0;
            end else begin
                expq.push_back(mk(0, 0, 0, 0, 0));
                break;
            end
            expq.push_back(mk(per, 0, 0, idx, 1));
        end
        while (expq.size() > n_max) void'(expq.pop_back());
    endtask

    // Pulses start in cycle t and compares every following cycle with the model;
    // an optional extra start pulse is driven at offset inject.
    task automatic applyStimulus(string name, int inject);
        start = 1'b1;
        tick();
        start = 1'b0;
        strobe_at.delete();
        for (int c = 0; c < expq.size(); c++) begin
            checkObs($sformatf("%s t+%0d", name, c + 1), expq[c]);
            if (note_strobe) strobe_at.push_back(c + 1);
            start = (inject == c + 1);
            tick();
        end
        start = 1'b0;
    endtask

    vec_t vecs [8];
    int   cnt, last;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int exp_strobes [3] = '{2, 16, 40};

        vecs[0] = '{8'h20, 190839, 1, 10};
        vecs[1] = '{8'hFF, 101214, 1, 80};
        vecs[2] = '{8'hD0,  28409, 1, 10};
        vecs[3] = '{8'h00,      0, 0, 10};
        vecs[4] = '{8'h48,  85033, 1, 10};
        vecs[5] = '{8'h6B,  75757, 1, 40};
        vecs[6] = '{8'h95,  35816, 1, 60};
        vecs[7] = '{8'hE2, 101214, 1, 30};

        if (GC >= 20'(BM)) begin
            $display("[TB] FAIL param: GAP_CYCLES=%0d not below BEAT_MAX=%0d", GC, BM);
            $fatal(1, "[TB] bad parameters");
        end

        sys_rst = 1'b1; start = 1'b1; stop = 1'b0; loop = 1'b0;
        len_last = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 32; i++) song[i] = '0;
        tick();
        tick();
        checkObs("reset with start held", mk(0, 0, 0, 0, 0));
        sys_rst = 1'b0; start = 1'b0;
        tick();
        checkOutput("busy after reset release", int'(busy), 0);

        for (int i = 0; i < 32; i++) writeEntry(i, 8'h00);

        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checkOutput("start+stop idle busy", int'(busy), 0);
        tick();
        checkOutput("start+stop idle busy later", int'(busy), 0);

        foreach (vecs[v]) begin
            writeEntry(0, vecs[v].data);
            len_last = 5'd0; loop = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            checkOutput($sformatf("vec%0d strobe", v), int'(note_strobe), 1);
            checkOutput($sformatf("vec%0d freq", v), int'(freq_data), vecs[v].freq);
            checkOutput($sformatf("vec%0d tone", v), int'(tone_en), vecs[v].tone);
            cnt = 0;
            while (busy && cnt < 300) begin
                tick();
                cnt++;
            end
            checkOutput($sformatf("vec%0d cycles to idle", v), cnt, vecs[v].play + GAPN);
        end

        writeEntry(0, 8'h20); writeEntry(1, 8'hA9); writeEntry(2, 8'h00);
        len_last = 5'd2; loop = 1'b0;
        buildModel(100000, 1'b0, 2);
        applyStimulus("song3", 0);
        checkOutput("song3 strobe count", strobe_at.size(), 3);
        for (int i = 0; i < strobe_at.size() && i < 3; i++)
            checkOutput($sformatf("song3 strobe%0d time", i), strobe_at[i], exp_strobes[i]);

        buildModel(100000, 1'b0, 2);
        applyStimulus("song3 start in PLAY", 20);

        loop = 1'b1;
        buildModel(59, 1'b1, 2);
        applyStimulus("loop", 0);
        checkOutput("loop strobe count", strobe_at.size(), 4);
        if (strobe_at.size() == 4) checkOutput("loop restrobe time", strobe_at[3], 54);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkObs("stop at t+61", mk(0, 0, 0, 0, 0));
        loop = 1'b0;

        writeEntry(0, 8'h20);
        len_last = 5'd0; loop = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'hD0;
        tick();
        wr_en = 1'b0; song[0] = 8'hD0;
        checkOutput("fetch-write old strobe", int'(note_strobe), 1);
        checkOutput("fetch-write old freq", int'(freq_data), 190839);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!note_strobe && cnt < 100);
        checkOutput("fetch-write next pass delay", cnt, 14);
        checkOutput("fetch-write new freq", int'(freq_data), 28409);
        stop = 1'b1;
        tick();
        stop = 1'b0; loop = 1'b0;

        writeEntry(0, 8'hFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        checkOutput("pre-reset tone", int'(tone_en), 1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        checkObs("mid-play reset", mk(0, 0, 0, 0, 0));
        repeat (20) tick();
        checkOutput("no resume after reset", int'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkObs("restart after reset", mk(101214, 1, 1, 0, 1));
        stop = 1'b1;
        tick();
        stop = 1'b0;

        for (int r = 0; r < 4; r++) begin
            last = int'($urandom_range(0, 4));
            len_last = 5'(last);
            for (int a = 0; a <= last; a++) writeEntry(a, 8'($urandom));
            buildModel(100000, 1'b0, last);
            applyStimulus($sformatf("rand%0d", r), 0);
        end

        last = int'($urandom_range(1, 3));
        len_last = 5'(last); loop = 1'b1;
        for (int a = 0; a <= last; a++) writeEntry(a, 8'($urandom) & 8'hF8);
        buildModel(150, 1'b1, last);
        applyStimulus("randloop", 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkObs("randloop stop", mk(0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
